// File: rtl/side_vram_sched_if.sv
// side_vram_sched_if: CPU request/acknowledge channel into the side VRAM scheduler
interface side_vram_sched_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_ack;
    logic [7:0]  cpu_dout;
    modport master (output cpu_req, cpu_we, cpu_addr, cpu_din, input cpu_ack, cpu_dout);
    modport slave  (input cpu_req, cpu_we, cpu_addr, cpu_din, output cpu_ack, cpu_dout);
endinterface

// File: rtl/side_vram_sched.sv
// side_vram_sched: 8-phase pixel-slot sequencer and CPU/video arbiter for the side VRAM
module side_vram_sched #(
    parameter int CPU_PHASE = 4,
    parameter int VLK_PHASE = 1
) (
    input  logic              clk,
    input  logic              VIDEO_RST,
    input  logic              CK1,
    input  logic              HSYNC_START,
    input  logic              DISP_EN,
    side_vram_sched_if.slave  cpu,
    output logic [10:0]       VA,
    output logic [7:0]        VD_out,
    input  logic [7:0]        VD_in,
    output logic              V_C,
    output logic              SIDE_VRAM_CSn,
    output logic              VWE,
    output logic              VOE,
    output logic              VRD,
    output logic              VDG,
    output logic              VFLGn,
    output logic              H2n,
    output logic              H1n,
    output logic              H0n,
    output logic              VLK,
    output logic              LD_G,
    output logic              LD_C
);
    localparam logic [1:0] IDLE = 2'd0, PEND = 2'd1, ACCESS = 2'd2, DONE = 2'd3;
    localparam logic [2:0] PRE_PH = 3'(CPU_PHASE - 1);
    localparam logic [2:0] VLK_PH = 3'(VLK_PHASE);
    logic [2:0] ph;
    logic [1:0] state, cnt;
    logic       we_r;
    logic [7:0] dout;
    always_ff @(posedge clk or posedge VIDEO_RST)
        if (VIDEO_RST) ph <= 3'd0;
        else if (CK1) ph <= HSYNC_START ? 3'd0 : ph + 3'd1;
    assign {H2n, H1n, H0n} = ~ph;
    assign VLK   = CK1 & ~VIDEO_RST & (ph == VLK_PH);
    assign LD_G  = CK1 & ~VIDEO_RST & (ph == 3'd7);
    assign LD_C  = CK1 & ~VIDEO_RST & ph[0];
    assign VFLGn = VIDEO_RST | ~(DISP_EN & ~ph[2] & ~ph[1]);
    assign cpu.cpu_ack  = state == DONE;
    assign cpu.cpu_dout = dout;
    // The access window is timed by its own tick count so a line restart cannot cut it short.
    always_ff @(posedge clk or posedge VIDEO_RST)
        if (VIDEO_RST) begin
            state         <= IDLE;
            cnt           <= 2'd0;
            we_r          <= 1'b0;
            VA            <= 11'd0;
            VD_out        <= 8'd0;
            dout          <= 8'd0;
            V_C           <= 1'b0;
            SIDE_VRAM_CSn <= 1'b1;
            VDG           <= 1'b1;
            VWE           <= 1'b1;
            VOE           <= 1'b1;
            VRD           <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cpu.cpu_req) begin
                    VA     <= cpu.cpu_addr;
                    VD_out <= cpu.cpu_din;
                    we_r   <= cpu.cpu_we;
                    state  <= PEND;
                end
                PEND: if (CK1 && ph == PRE_PH) begin
                    state         <= ACCESS;
                    cnt           <= 2'd0;
                    V_C           <= 1'b1;
                    SIDE_VRAM_CSn <= 1'b0;
                    VDG           <= 1'b0;
                    VRD           <= we_r;
                    VOE           <= we_r;
                end
                ACCESS: if (CK1) begin
                    cnt <= cnt + 2'd1;
                    VWE <= ~(we_r && cnt == 2'd0);
                    if (cnt == 2'd2) begin
                        state         <= DONE;
                        V_C           <= 1'b0;
                        SIDE_VRAM_CSn <= 1'b1;
                        VDG           <= 1'b1;
                        VOE           <= 1'b1;
                        VRD           <= 1'b0;
                        if (!we_r) dout <= VD_in;
                    end
                end
                default: state <= IDLE;
            endcase
        end
endmodule
